// File: rtl/mcu_o_reg_sequencer.sv
// Pattern sequencer: steps a CPU-loaded table out to the 8-bit output-port slave, one entry per period.
// Define MCU_O_SEQ_IRQ_EN to add the irq output and the CONTROL.IRQ_EN bit.
module mcu_o_reg_sequencer #(
  parameter int TABLE_DEPTH = 16,
  parameter int PERIOD_W    = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
`ifdef MCU_O_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int         PTR_W  = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(TABLE_DEPTH);

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_STAT = 3'd1;
  localparam logic [2:0] A_PER  = 3'd2;
  localparam logic [2:0] A_LEN  = 3'd3;
  localparam logic [2:0] A_TPTR = 3'd4;
  localparam logic [2:0] A_TDAT = 3'd5;
  localparam logic [2:0] A_STEP = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_run, r_loop, r_done;
  logic [PERIOD_W-1:0]   r_period, r_count, w_count_nxt;
  logic [3:0]            r_length;
  logic [PTR_W-1:0]      r_tptr, r_step, w_step_nxt, w_last;
  logic [7:0]            r_table [TABLE_DEPTH];
  logic                  r_m_cs, r_m_wr_n;
  logic [31:0]           r_m_wdata;

  logic w_wr, w_ctrl_wr, w_stat_wr, w_per_wr, w_len_wr, w_tptr_wr, w_tdat_wr;
  logic w_abort, w_run_nxt, w_done_nxt, w_done_set, w_start, w_next, w_strobe_nxt;
  logic w_busy, w_per_le1, w_irq_en_rd;
  logic w_unused;

  // Only the low byte/field of s_writedata is meaningful for most registers.
  assign w_unused = &{1'b0, s_writedata};

  assign w_wr      = s_chipselect & ~s_write_n;
  assign w_ctrl_wr = w_wr && (s_address == A_CTRL);
  assign w_stat_wr = w_wr && (s_address == A_STAT);
  assign w_per_wr  = w_wr && (s_address == A_PER);
  assign w_len_wr  = w_wr && (s_address == A_LEN);
  assign w_tptr_wr = w_wr && (s_address == A_TPTR);
  assign w_tdat_wr = w_wr && (s_address == A_TDAT);
  assign w_abort   = w_ctrl_wr && !s_writedata[0];

  assign w_busy    = (r_state != S_IDLE);
  assign w_per_le1 = (r_period <= PERIOD_W'(1));

  // LENGTH of 0 or beyond the table means "use the whole table".
  always_comb begin
    if (r_length == 4'd0 || {1'b0, r_length} > DEPTH5)
      w_last = PTR_W'(TABLE_DEPTH - 1);
    else
      w_last = PTR_W'(r_length - 4'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_count_nxt  = r_count;
    w_run_nxt    = w_ctrl_wr ? s_writedata[0] : r_run;
    w_done_set   = 1'b0;
    w_start      = 1'b0;
    w_next       = 1'b0;
    w_strobe_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_run_nxt) begin
          w_state_nxt  = S_WRITE;
          w_step_nxt   = '0;
          w_start      = 1'b1;
          w_strobe_nxt = 1'b1;
        end
      end
      S_WRITE: begin
        if (w_abort)        w_state_nxt = S_IDLE;
        else if (w_per_le1) w_next      = 1'b1;
        else begin
          w_state_nxt = S_WAIT;
          w_count_nxt = r_period - PERIOD_W'(1);
        end
      end
      S_WAIT: begin
        // Count reaching zero this cycle means the next strobe lands exactly PERIOD after the last.
        if (w_abort)                        w_state_nxt = S_IDLE;
        else if (r_count <= PERIOD_W'(1))   w_next      = 1'b1;
        else                                w_count_nxt = r_count - PERIOD_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_next) begin
      if (r_step < w_last) begin
        w_step_nxt   = r_step + PTR_W'(1);
        w_state_nxt  = S_WRITE;
        w_strobe_nxt = 1'b1;
      end else if (r_loop) begin
        w_step_nxt   = '0;
        w_state_nxt  = S_WRITE;
        w_strobe_nxt = 1'b1;
      end else begin
        w_run_nxt   = 1'b0;
        w_done_set  = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_comb begin
    w_done_nxt = r_done;
    if (w_stat_wr && s_writedata[1]) w_done_nxt = 1'b0;
    if (w_start)                     w_done_nxt = 1'b0;
    if (w_done_set)                  w_done_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run     <= 1'b0;
      r_loop    <= 1'b0;
      r_done    <= 1'b0;
      r_period  <= '0;
      r_count   <= '0;
      r_length  <= '0;
      r_tptr    <= '0;
      r_step    <= '0;
      r_m_cs    <= 1'b0;
      r_m_wr_n  <= 1'b1;
      r_m_wdata <= '0;
      for (int i = 0; i < TABLE_DEPTH; i++) r_table[i] <= '0;
    end else begin
      r_run   <= w_run_nxt;
      r_done  <= w_done_nxt;
      r_count <= w_count_nxt;
      r_step  <= w_step_nxt;
      if (w_ctrl_wr) r_loop   <= s_writedata[1];
      if (w_per_wr)  r_period <= s_writedata[PERIOD_W-1:0];
      if (w_len_wr)  r_length <= s_writedata[3:0];
      if (w_tptr_wr) r_tptr   <= s_writedata[PTR_W-1:0];
      if (w_tdat_wr) begin
        r_table[r_tptr] <= s_writedata[7:0];
        r_tptr          <= r_tptr + PTR_W'(1);
      end
      r_m_cs   <= w_strobe_nxt;
      r_m_wr_n <= ~w_strobe_nxt;
      if (w_strobe_nxt) r_m_wdata <= {24'd0, r_table[w_step_nxt]};
    end
  end

`ifdef MCU_O_SEQ_IRQ_EN
  logic r_irq_en, r_irq, w_irq_en_nxt;

  assign w_irq_en_nxt = w_ctrl_wr ? s_writedata[2] : r_irq_en;
  assign w_irq_en_rd  = r_irq_en;
  assign irq          = r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_nxt;
      r_irq    <= w_done_nxt & w_irq_en_nxt;
    end
  end
`else
  assign w_irq_en_rd = 1'b0;
`endif

  always_comb begin
    s_readdata = '0;
    case (s_address)
      A_CTRL:  s_readdata = {29'd0, w_irq_en_rd, r_loop, r_run};
      A_STAT:  s_readdata = {30'd0, r_done, w_busy};
      A_PER:   s_readdata = 32'(r_period);
      A_LEN:   s_readdata = {28'd0, r_length};
      A_TPTR:  s_readdata = 32'(r_tptr);
      A_TDAT:  s_readdata = {24'd0, r_table[r_tptr]};
      A_STEP:  s_readdata = 32'(r_step);
      default: s_readdata = '0;
    endcase
  end

  assign m_address    = 2'd0;
  assign m_chipselect = r_m_cs;
  assign m_write_n    = r_m_wr_n;
  assign m_writedata  = r_m_wdata;

endmodule

// File: doc/mcu_o_reg_sequencer.md
# mcu_o_reg_sequencer

Autonomous pattern sequencer that drives the 8-bit output-port register slave (Avalon-MM, address 0 = data) from a 16-entry pattern table, one entry per programmable period. Sits between the Nios/MCU data master and the output-port slave. The CPU configures it through its own Avalon-MM slave. The block then issues zero-wait-state writes to the output-port register with no CPU involvement.

## Interface
Parameters:
- TABLE_DEPTH, 16: pattern entries; power of two, 2..16.
- PERIOD_W, 24: width of the step-period counter.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- s_address  in  3  CPU slave word address.
- s_chipselect  in  1  CPU slave select.
- s_write_n  in  1  CPU write strobe, active low.
- s_writedata  in  32  CPU write data.
- s_readdata  out  32  CPU read data; combinational, zero wait states.
- m_address  out  2  to output-port slave address; constant 0.
- m_chipselect  out  1  to output-port slave chipselect.
- m_write_n  out  1  to output-port slave write_n, active low.
- m_writedata  out  32  to output-port slave writedata: {24'b0, entry}.
- irq  out  1  only present with MCU_O_SEQ_IRQ_EN.

## Operation
CPU register map, unused bits read 0:
- 0 CONTROL rw: bit0 RUN, bit1 LOOP, bit2 IRQ_EN (IRQ_EN only with macro).
- 1 STATUS: bit0 BUSY (ro), bit1 DONE (write 1 to clear).
- 2 PERIOD rw: PERIOD_W bits, cycles per step; 0 treated as 1.
- 3 LENGTH rw: 4 bits; entries used = LENGTH, 0 means TABLE_DEPTH; values above TABLE_DEPTH are clamped to TABLE_DEPTH.
- 4 TPTR rw: table pointer, log2(TABLE_DEPTH) bits.
- 5 TDATA: write stores s_writedata[7:0] at table[TPTR] and post-increments TPTR with wrap. Read returns table[TPTR] without incrementing.
- 6 STEP ro: current table index.

State machine IDLE / WRITE / WAIT:
- IDLE -> WRITE when RUN=1. STEP=0; clears DONE.
- WRITE: one cycle with m_chipselect=1, m_write_n=0, m_writedata={24'b0, table[STEP]}. Moves to WAIT with count=PERIOD-1, or straight to NEXT handling when PERIOD<=1.
- WAIT: decrement count. At 0, perform NEXT.
- NEXT when STEP<last: STEP+1, go to WRITE.
- NEXT when STEP=last and LOOP=1: STEP=0, go to WRITE.
- NEXT when STEP=last and LOOP=0: RUN cleared, DONE set, go to IDLE.
- BUSY = (state != IDLE).
- RUN written 0 while busy: abort to IDLE next cycle. No further writes; DONE is not set; the port holds its last value.
- RUN written 1 while busy: ignored; no restart.
- PERIOD, LENGTH and table writes while busy: take effect at the next WAIT load, NEXT compare, or entry fetch respectively.
- DONE set and CPU clear in the same cycle: set wins.
- The block never reads the output-port slave.

## Timing
- Reset values: s_readdata 0, m_address 0, m_chipselect 0, m_write_n 1, m_writedata 0, irq 0. All registers, table and STEP are 0; state is IDLE.
- CPU write of RUN=1 in cycle N puts the first m_ write strobe in cycle N+1.
- With PERIOD=P (P>=1), consecutive write strobes are exactly P cycles apart, including across loop wrap.
- Completion (LOOP=0): the last strobe occurs in cycle T. DONE=1 and BUSY=0 are visible from cycle T+P.
- Abort: RUN=0 written in cycle N gives no strobe from N+1 onward, with BUSY=0 at N+1.
- All master outputs are registered.

## Configuration
- MCU_O_SEQ_IRQ_EN defined: irq port exists; irq = DONE & IRQ_EN, registered, and it drops the cycle after DONE is cleared.
- Not defined: no irq port, CONTROL bit2 ignored and read as 0.

## Test plan
- Reset, then read all registers -> all 0. m_write_n=1 and m_chipselect=0.
- Load table 0x01,0x02,0x04,0x08; LENGTH=4; PERIOD=3; RUN=1, LOOP=0 -> strobes carry 0x01,0x02,0x04,0x08, 3 cycles apart. DONE=1 three cycles after the last strobe, then RUN=0.
- Same setup with LOOP=1 and PERIOD=1 -> strobe every cycle, sequence 01,02,04,08,01,… with no gap at wrap.
- Abort: RUN=0 during WAIT after entry 2 -> no further strobes, DONE=0, BUSY=0 next cycle.
- PERIOD=0, LENGTH=0 with a 16-entry table -> all 16 entries written on consecutive cycles. TDATA readback after TPTR=5 returns table[5].
- With macro, IRQ_EN=1: completion gives irq=1; write STATUS=0x2 -> irq=0 next cycle; clear coincident with set -> DONE stays 1.
